jk_sync_counter: RTL and testbench
==================================

Name: jk_sync_counter

Overview:
Synchronous modulo-N up/down counter built from JK storage cells. It is the stage directly downstream of the JK flip-flop. A next-state decoder computes the J/K drive for every bit, which turns the flip-flop into a loadable, enable-gated counting stage. Typical uses are the BCD digit counter and the clock-divide stage of the lab datapath. Terminal-count and wrap outputs let instances be cascaded.

Parameters:
WIDTH, 4, counter bit width
MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH (elaboration error otherwise)

Ports:
CLK  in  1  clock; all state changes on the rising edge
CLR  in  1  reset, synchronous, active-high
EN  in  1  count enable
UP  in  1  direction: 1 = increment, 0 = decrement
LOAD  in  1  synchronous parallel load
D  in  WIDTH  load value
Q  out  WIDTH  current count
P  out  WIDTH  bitwise complement of Q (same convention as the flip-flop's P output)
TC  out  1  terminal count, combinational
WRAP  out  1  registered one-cycle pulse, asserted the cycle after a wrap
LDERR  out  1  registered one-cycle pulse, asserted the cycle after an illegal load

Behaviour:
- All sequential outputs update only on the rising edge of CLK. There is no asynchronous path.
- Priority at each edge is CLR > LOAD > EN > hold.
- CLR=1: Q=0, WRAP=0, LDERR=0. These are also the reset values. P follows Q, so P = all ones after reset.
- LOAD=1 with D < MODULUS: Q=D, WRAP=0, LDERR=0.
- LOAD=1 with D >= MODULUS: Q holds, LDERR=1 for exactly one cycle, WRAP=0.
- EN=1, UP=1: Q = Q+1. If Q==MODULUS-1, Q=0 and WRAP=1 next cycle.
- EN=1, UP=0: Q = Q-1. If Q==0, Q=MODULUS-1 and WRAP=1 next cycle.
- EN=0 (no LOAD, no CLR): Q holds, WRAP=0, LDERR=0.
- TC = EN & ((UP & Q==MODULUS-1) | (~UP & Q==0)). TC is combinational and intended as the EN of the next cascaded stage. It can be 1 straight out of reset when EN=1 and UP=0.
- Latency: Q reflects a count, load or clear one cycle after the qualifying edge. WRAP and LDERR appear in the same cycle that Q shows the wrapped or held value.
- Per-bit JK drive from next-state N:
  - J[i] = N[i] & ~Q[i]
  - K[i] = ~N[i] & Q[i]
  - This never produces J=K=1, so no toggle ambiguity. Clear is applied inside the cell.
- UP changing while EN=1 is legal and takes effect at the same edge.
- With MODULUS == 2**WIDTH the natural binary rollover equals the wrap. WRAP must still pulse on it.
- Q never holds a value >= MODULUS after any edge, under any input sequence.
- CLR asserted mid-count overrides a simultaneous LOAD or EN. WRAP and LDERR clear in the same edge.

Decomposition:
- Shared package (jk_pkg) holds:
  - JK encoding constants: HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11
  - function for legal-modulus checking
- One sub-module: jk_cell, a single JK storage bit.
  - Ports: CLK, CLR (sync active-high), J, K, Q, P.
  - Instantiated WIDTH times via generate.
- The counter owns only the next-state decode and the WRAP/LDERR registers.

Test Plan (WIDTH=4, MODULUS=10, CLK period 100):
- CLR=1 for 2 edges, then EN=0 -> Q=0, P=4'hF, WRAP=0, LDERR=0. Q holds 0 for 3 further edges.
- CLR=0, EN=1, UP=1 for 12 edges -> Q steps 1..9, 0, 1, 2.
  - TC=1 only while Q=9.
  - WRAP=1 only in the cycle Q becomes 0.
- LOAD=1, D=7 -> Q=7. Then EN=1, UP=0 for 9 edges -> Q steps 6..0, 9, 8.
  - TC=1 while Q=0.
  - WRAP pulses with Q=9.
- LOAD=1, D=12 with Q=4 -> Q stays 4 and LDERR=1 for one cycle. Then LOAD=1, D=9 -> Q=9, LDERR=0.
- At Q=9: LOAD=1, D=3 together with EN=1, UP=1 -> Q=3, WRAP=0 (load wins). Next edge: CLR=1, LOAD=1, EN=1 -> Q=0 (clear wins).
- Two instances cascaded (units TC -> tens EN), EN=1, UP=1, 100 edges from reset -> tens:units reads 0:0 with tens WRAP pulsing once. A random-stimulus check confirms Q<10 on every cycle.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: definitions shared by the JK storage cell and the JK-based counter.
//   - JK drive encodings, packed as {J, K}
//   - modulus_legal(): elaboration-time range check for a counter modulus
package jk_pkg;

    // JK drive encodings, packed as {J, K}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // A modulus is legal when 2 <= modulus <= 2**width. The comparison is done at 64 bits so
    // that width = 32 does not overflow.
    function automatic logic modulus_legal(input int unsigned width, input int unsigned modulus);
        longint unsigned limit;
        limit = 64'd1 << width;
        return (modulus >= 2) && (longint'(modulus) <= limit);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK storage bit with synchronous active-high clear.
// Ports:
//   CLK  in   clock, rising edge
//   CLR  in   synchronous clear, active-high, overrides J/K
//   J    in   set drive
//   K    in   reset drive
//   Q    out  stored bit
//   P    out  complement of Q
module jk_cell
    import jk_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic P
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case ({J, K})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;
    assign P = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: synchronous modulo-MODULUS up/down counter built from jk_cell bits.
// The counter decodes the next count and converts it into per-bit J/K drive. It also
// registers the WRAP and LDERR pulses.
// Parameters:
//   WIDTH    counter width
//   MODULUS  count range 0..MODULUS-1, legal range 2..2**WIDTH
// Ports:
//   CLK    in   clock, rising edge
//   CLR    in   synchronous clear, active-high (highest priority)
//   EN     in   count enable
//   UP     in   1 = increment, 0 = decrement
//   LOAD   in   synchronous parallel load (beats EN)
//   D      in   load value; values >= MODULUS are rejected
//   Q      out  current count
//   P      out  ~Q
//   TC     out  terminal count (combinational), for the EN of a cascaded stage
//   WRAP   out  one-cycle pulse in the cycle after a wrap-around
//   LDERR  out  one-cycle pulse in the cycle after a rejected load
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] P,
    output logic             TC,
    output logic             WRAP,
    output logic             LDERR
);

    if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("jk_sync_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // The modulus is kept one bit wider so that MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inv;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    logic             at_max;
    logic             at_zero;
    logic             wrap_d, wrap_q;
    logic             lderr_d, lderr_q;

    assign at_max  = (cnt == MAX_VAL);
    assign at_zero = (cnt == '0);

    // Next-state decode. CLR is not handled here because the cells apply it themselves.
    always_comb begin
        cnt_next = cnt;
        wrap_d   = 1'b0;
        lderr_d  = 1'b0;
        if (LOAD) begin
            if ({1'b0, D} < MOD_EXT) begin
                cnt_next = D;
            end else begin
                lderr_d = 1'b1;
            end
        end else if (EN) begin
            if (UP) begin
                if (at_max) begin
                    cnt_next = '0;
                    wrap_d   = 1'b1;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    cnt_next = MAX_VAL;
                    wrap_d   = 1'b1;
                end else begin
                    cnt_next = cnt - WIDTH'(1);
                end
            end
        end
    end

    // Drive each bit toward its next value. J and K are never both high, so no cell toggles.
    assign j_drv = cnt_next & ~cnt;
    assign k_drv = ~cnt_next & cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .CLK (CLK),
            .CLR (CLR),
            .J   (j_drv[i]),
            .K   (k_drv[i]),
            .Q   (cnt[i]),
            .P   (cnt_inv[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wrap_q  <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            wrap_q  <= wrap_d;
            lderr_q <= lderr_d;
        end
    end

    assign Q     = cnt;
    assign P     = cnt_inv;
    assign TC    = EN & ((UP & at_max) | (~UP & at_zero));
    assign WRAP  = wrap_q;
    assign LDERR = lderr_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Testbench for jk_sync_counter (WIDTH=4, MODULUS=10), with a units/tens cascade and a
// MODULUS=16 instance. Expected states come from a behavioural model. Each expected state is
// queued when its edge is driven and compared after that edge.
module tb_jk_sync_counter;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] p;
        logic       wrap;
        logic       lderr;
        logic       tc;     // TC observed just before the edge
    } obs_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] q, p;
    logic       tc, wrap, lderr;

    // Cascade / boundary instances
    logic       c_clr = 1'b1;
    logic       c_en = 1'b0;
    logic [3:0] u_q, u_p, t_q, t_p, m_q16, m_p16;
    logic       u_tc, u_wrap, u_lderr, t_tc, t_wrap, t_lderr, m_tc16, m_wrap16, m_lderr16;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];
    obs_t obs;
    obs_t e;

    // Model state
    int   m_q = 0;
    logic m_wrap = 1'b0;
    logic m_lderr = 1'b0;

    always #50 clk = ~clk;

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .CLK(clk), .CLR(clr), .EN(en), .UP(up), .LOAD(load), .D(d),
        .Q(q), .P(p), .TC(tc), .WRAP(wrap), .LDERR(lderr)
    );

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_units (
        .CLK(clk), .CLR(c_clr), .EN(c_en), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
        .Q(u_q), .P(u_p), .TC(u_tc), .WRAP(u_wrap), .LDERR(u_lderr)
    );

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
        .CLK(clk), .CLR(c_clr), .EN(u_tc), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
        .Q(t_q), .P(t_p), .TC(t_tc), .WRAP(t_wrap), .LDERR(t_lderr)
    );

    jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_full (
        .CLK(clk), .CLR(c_clr), .EN(c_en), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
        .Q(m_q16), .P(m_p16), .TC(m_tc16), .WRAP(m_wrap16), .LDERR(m_lderr16)
    );

    // Drive one edge: apply inputs, queue the model's expectation, sample after the edge.
    task automatic drive_edge(input logic i_clr, input logic i_load, input logic i_en,
                              input logic i_up, input logic [3:0] i_d);
        obs_t x;
        logic tc_s;
        @(negedge clk);
        clr = i_clr; load = i_load; en = i_en; up = i_up; d = i_d;
        x.tc = i_en & ((i_up & (m_q == 9)) | (!i_up & (m_q == 0)));
        if (i_clr) begin
            m_q = 0; m_wrap = 1'b0; m_lderr = 1'b0;
        end else if (i_load) begin
            m_wrap = 1'b0;
            if (int'(i_d) < 10) begin
                m_q = int'(i_d); m_lderr = 1'b0;
            end else begin
                m_lderr = 1'b1;
            end
        end else if (i_en) begin
            m_lderr = 1'b0;
            m_wrap  = i_up ? (m_q == 9) : (m_q == 0);
            m_q     = i_up ? (m_q + 1) % 10 : (m_q + 9) % 10;
        end else begin
            m_wrap = 1'b0; m_lderr = 1'b0;
        end
        x.q = 4'(m_q); x.p = ~4'(m_q); x.wrap = m_wrap; x.lderr = m_lderr;
        sb.push_back(x);
        #1 tc_s = tc;
        @(posedge clk);
        #1 obs = '{q: q, p: p, wrap: wrap, lderr: lderr, tc: tc_s};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            drive_edge(i < 2, 1'b0, 1'b0, 1'b1, 4'd0);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset[%0d] got q=%h p=%h w=%b le=%b tc=%b want q=%h p=%h w=%b le=%b tc=%b",
                         i, obs.q, obs.p, obs.wrap, obs.lderr, obs.tc,
                         e.q, e.p, e.wrap, e.lderr, e.tc);
            end
        end
        checks++;
        if ({q, p, wrap, lderr} !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_const got q=%h p=%h w=%b le=%b want q=0 p=f w=0 le=0",
                     q, p, wrap, lderr);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int i = 0; i < 12; i++) begin
            drive_edge(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            e = sb.pop_front();
            checks++;
            if (obs !== e || q !== seq[i] || wrap !== (seq[i] == 0)) begin
                errors++;
                $display("FAIL count_up[%0d] got q=%h w=%b tc=%b want q=%h w=%b tc=%b",
                         i, obs.q, obs.wrap, obs.tc, seq[i], e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] seq[9] = '{6, 5, 4, 3, 2, 1, 0, 9, 8};
        drive_edge(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        e = sb.pop_front();
        checks++;
        if (obs !== e || q !== 4'd7) begin
            errors++;
            $display("FAIL load7 got q=%h le=%b want q=7 le=0", obs.q, obs.lderr);
        end
        for (int i = 0; i < 9; i++) begin
            drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            e = sb.pop_front();
            checks++;
            if (obs !== e || q !== seq[i] || wrap !== (seq[i] == 9)) begin
                errors++;
                $display("FAIL count_down[%0d] got q=%h w=%b tc=%b want q=%h w=%b tc=%b",
                         i, obs.q, obs.wrap, obs.tc, seq[i], e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_load_error();
        logic [3:0] ld[3]   = '{4, 12, 9};
        logic [3:0] want[3] = '{4, 4, 9};
        logic       le[3]   = '{0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b1, 1'b0, 1'b1, ld[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e || q !== want[i] || lderr !== le[i]) begin
                errors++;
                $display("FAIL load_err[%0d] got q=%h le=%b want q=%h le=%b",
                         i, obs.q, obs.lderr, want[i], le[i]);
            end
        end
    endtask

    task automatic test_priority();
        drive_edge(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        e = sb.pop_front();
        checks++;
        if (obs !== e || q !== 4'd3 || wrap !== 1'b0 || obs.tc !== 1'b1) begin
            errors++;
            $display("FAIL load_over_en got q=%h w=%b tc=%b want q=3 w=0 tc=1",
                     obs.q, obs.wrap, obs.tc);
        end
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        e = sb.pop_front();
        checks++;
        if (obs !== e || q !== 4'd0) begin
            errors++;
            $display("FAIL clr_over_all got q=%h w=%b le=%b want q=0 w=0 le=0",
                     obs.q, obs.wrap, obs.lderr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_edge($urandom_range(15) == 0, $urandom_range(3) == 0, 1'($urandom),
                       1'($urandom), 4'($urandom_range(15)));
            e = sb.pop_front();
            checks++;
            if (obs !== e || q >= 4'd10) begin
                errors++;
                $display("FAIL random[%0d] got q=%h p=%h w=%b le=%b tc=%b want q=%h p=%h w=%b le=%b tc=%b",
                         i, obs.q, obs.p, obs.wrap, obs.lderr, obs.tc,
                         e.q, e.p, e.wrap, e.lderr, e.tc);
            end
        end
    endtask

    task automatic test_cascade();
        int t_wraps = 0;
        int u_wraps = 0;
        int f_wraps = 0;
        @(negedge clk);
        c_clr = 1'b1; c_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        c_clr = 1'b0;
        checks++;
        if ({t_q, u_q, m_q16} !== 12'h000) begin
            errors++;
            $display("FAIL cascade_reset got %h:%h full=%h want 0:0 full=0", t_q, u_q, m_q16);
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            t_wraps += int'(t_wrap);
            u_wraps += int'(u_wrap);
            f_wraps += int'(m_wrap16);
        end
        checks++;
        if ({t_q, u_q, t_p, u_p} !== 16'h00FF || t_wraps != 1 || u_wraps != 10) begin
            errors++;
            $display("FAIL cascade got %h:%h p=%h:%h tens_wraps=%0d units_wraps=%0d want 0:0 p=f:f 1 10",
                     t_q, u_q, t_p, u_p, t_wraps, u_wraps);
        end
        checks++;
        if (m_q16 !== 4'd4 || m_p16 !== 4'hB || f_wraps != 6) begin
            errors++;
            $display("FAIL mod16_rollover got q=%h p=%h wraps=%0d want q=4 p=b wraps=6",
                     m_q16, m_p16, f_wraps);
        end
        checks++;
        if ({t_tc, m_tc16, u_lderr, t_lderr, m_lderr16} !== 5'b0) begin
            errors++;
            $display("FAIL cascade_flags got tc=%b%b lderr=%b%b%b want all 0",
                     t_tc, m_tc16, u_lderr, t_lderr, m_lderr16);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_error();
        test_priority();
        test_random();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
